ksa_engine: RTL and testbench
=============================

// Module: ksa_engine
// PURPOSE
//  Parametrised RC4 key-scheduling engine: fills the S-box RAM with s[i]=i,
//  then runs the KSA swap loop (j = j + s[i] + key[i mod KEY_BYTES]; swap s[i],s[j]).
//  Drives an external single-port RAM (write_mem-style, 1-cycle read latency).
//  Sits between the decryption top level and the S-box RAM, started by a one-cycle start pulse.
// PARAMETERS
//  ADDR_W     8  S-box address width; DEPTH = 2**ADDR_W entries
//  DATA_W     8  S-box word width; must be >= ADDR_W
//  KEY_BYTES  3  secret key length in bytes; key width = 8*KEY_BYTES
// PORTS
//  clk        in   1              system clock (CLOCK_50 domain)
//  reset_n    in   1              synchronous active-low reset
//  start      in   1              begin run; sampled only in IDLE
//  secret_key in   8*KEY_BYTES    key; byte 0 = secret_key[8*KEY_BYTES-1 -: 8]
//  busy       out  1              high while a run is in progress
//  done       out  1              one-cycle pulse at end of run
//  mem_addr   out  ADDR_W         RAM address
//  mem_wdata  out  DATA_W         RAM write data
//  mem_wren   out  1              RAM write enable
//  mem_rdata  in   DATA_W         RAM read data, valid the cycle after mem_addr presented
// BEHAVIOUR
//  - Reset (reset_n=0 at posedge): state IDLE; busy, done, mem_wren = 0; mem_addr, mem_wdata = 0;
//    i, j, key index = 0. Reset mid-run aborts immediately; RAM contents are then undefined.
//  - IDLE: start=1 latches secret_key, clears i/j/key index -> INIT. start while not IDLE ignored
//    (including the DONE cycle); key changes after the start edge have no effect.
//  - INIT: each cycle mem_addr=i, mem_wdata=i (zero-extended), mem_wren=1; i++.
//    After i=DEPTH-1 written: i=0 -> RD_I. DEPTH cycles.
//  - Scramble iteration, 6 cycles, mem_wren=0 except where stated:
//    RD_I    mem_addr=i
//    LAT_I   si <= mem_rdata; j <= (j + si + key[kidx]) mod DEPTH (low ADDR_W bits)
//    RD_J    mem_addr=j
//    LAT_J   sj <= mem_rdata
//    WR_I    mem_addr=i, mem_wdata=sj, mem_wren=1
//    WR_J    mem_addr=j, mem_wdata=si, mem_wren=1; i++; kidx wraps KEY_BYTES-1 -> 0;
//            if i was DEPTH-1 -> DONE else -> RD_I
//  - i == j: both writes hit the same word; final value = original si (correct no-op swap).
//  - DONE: done=1, busy=0 for one cycle -> IDLE.
//  - busy=1 from the cycle after the start edge through WR_J of the last iteration.
//  - Latency: start sampled at edge k -> done high in cycle k+1+7*DEPTH (1792 for DEPTH=256).
//  - Key index kept as a wrapping counter, no divider; j and i wrap mod DEPTH.
// CONFIGURATION
//  KSA_CYCLE_CNT_EN defined: adds output cycle_cnt [31:0]; cleared at accepted start, increments
//    each busy cycle, holds after done until next start; reset value 0.
//  Undefined: port absent, no counter logic; all other behaviour identical.
// TESTING
//  ADDR_W=2, KEY_BYTES=1, key=8'h00, start -> RAM = {0,2,3,1}, done 28 cycles after start edge.
//  ADDR_W=2, KEY_BYTES=1, key=8'h01 -> RAM = {0,2,3,1}; trace j = 1,2,3,0 per iteration.
//  Defaults, key=24'h000249 -> RAM matches software RC4 KSA model, done exactly 1792 cycles after start.
//  start pulsed again mid-scramble and on DONE cycle -> ignored; single done pulse; result unchanged.
//  reset_n=0 during WR_I -> next cycle busy=0, mem_wren=0; new start then gives correct full result.
//  KSA_CYCLE_CNT_EN, defaults -> cycle_cnt = 1792 at done, held until next start.

Source files
------------

// File: rtl/ksa_engine.sv
// ksa_engine: RC4 key-scheduling engine driving an external single-port
// S-box RAM with one cycle of read latency. A run fills s[i]=i and then does
// the swap loop j = j + s[i] + key[i mod KEY_BYTES]; swap(s[i], s[j]).
// Optional feature: define KSA_CYCLE_CNT_EN to add a 32-bit cycle_cnt output
// that counts the busy cycles of the most recent run.
//
// Handshake: start is a single-cycle request that is accepted only in IDLE.
// busy stays high from the cycle after acceptance through the final write.
// done pulses for exactly one cycle once the run has finished.
module ksa_engine #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int KEY_BYTES = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [8*KEY_BYTES-1:0] secret_key,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  output logic                   mem_wren,
  input  logic [DATA_W-1:0]      mem_rdata
`ifdef KSA_CYCLE_CNT_EN
  ,
  output logic [31:0]            cycle_cnt
`endif
);

  localparam int KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_RD_I, S_LAT_I, S_RD_J, S_LAT_J, S_WR_I, S_WR_J, S_DONE
  } state_t;

  state_t                 state, state_nxt;
  logic [ADDR_W-1:0]      i, j;
  logic [KIDX_W-1:0]      kidx;
  logic [DATA_W-1:0]      si, sj;
  logic [8*KEY_BYTES-1:0] key_q;
  logic [7:0]             key_byte;

  // Select key byte kidx; byte 0 is the most significant byte of the key.
  always_comb begin
    key_byte = '0;
    for (int b = 0; b < KEY_BYTES; b++) begin
      if (kidx == KIDX_W'(b)) key_byte = key_q[8*(KEY_BYTES-1-b) +: 8];
    end
  end

  // State register; a reset in the middle of a run aborts it immediately.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Datapath registers: the counters, the captured S-box words and the latched key.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      i     <= '0;
      j     <= '0;
      kidx  <= '0;
      si    <= '0;
      sj    <= '0;
      key_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            key_q <= secret_key;
            i     <= '0;
            j     <= '0;
            kidx  <= '0;
          end
        end
        S_INIT:  i <= i + 1'b1;  // wraps to 0 after the last entry
        S_LAT_I: begin
          si <= mem_rdata;
          // Truncating to ADDR_W bits gives the mod-DEPTH sum.
          j  <= j + ADDR_W'(mem_rdata) + ADDR_W'(key_byte);
        end
        S_LAT_J: sj <= mem_rdata;
        S_WR_J: begin
          i    <= i + 1'b1;
          kidx <= (kidx == KIDX_W'(KEY_BYTES - 1)) ? '0 : kidx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Next-state logic plus the Moore outputs that drive the RAM.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wren  = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_INIT;
      S_INIT: begin
        busy      = 1'b1;
        mem_addr  = i;
        mem_wdata = DATA_W'(i);
        mem_wren  = 1'b1;
        if (i == '1) state_nxt = S_RD_I;
      end
      S_RD_I: begin
        busy      = 1'b1;
        mem_addr  = i;
        state_nxt = S_LAT_I;
      end
      S_LAT_I: begin
        busy      = 1'b1;
        state_nxt = S_RD_J;
      end
      S_RD_J: begin
        busy      = 1'b1;
        mem_addr  = j;
        state_nxt = S_LAT_J;
      end
      S_LAT_J: begin
        busy      = 1'b1;
        state_nxt = S_WR_I;
      end
      S_WR_I: begin
        busy      = 1'b1;
        mem_addr  = i;
        mem_wdata = sj;
        mem_wren  = 1'b1;
        state_nxt = S_WR_J;
      end
      S_WR_J: begin
        // When i == j this second write lands last, so the word keeps s[i].
        busy      = 1'b1;
        mem_addr  = j;
        mem_wdata = si;
        mem_wren  = 1'b1;
        state_nxt = (i == '1) ? S_DONE : S_RD_I;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

`ifdef KSA_CYCLE_CNT_EN
  // Run-length counter: cleared when a start is accepted, then held after done.
  always_ff @(posedge clk) begin
    if (!reset_n)                     cycle_cnt <= '0;
    else if (state == S_IDLE && start) cycle_cnt <= '0;
    else if (busy)                    cycle_cnt <= cycle_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_ksa_engine.sv
// tb_ksa_engine: directed bench for ksa_engine.
// It drives two instances. The small one uses ADDR_W=2 and KEY_BYTES=1; the
// other uses the default parameters. Each instance has its own RAM model with
// one cycle of read latency.
module tb_ksa_engine;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  // ---------------- small instance (ADDR_W=2, KEY_BYTES=1) ----------------
  logic       start_s;
  logic [7:0] key_s;
  logic       busy_s, done_s, wren_s;
  logic [1:0] addr_s;
  logic [7:0] wdata_s, rdata_s;
  logic [7:0] mem_s [4];
  logic [1:0] wlog_s [$];
`ifdef KSA_CYCLE_CNT_EN
  logic [31:0] cnt_s;
`endif

  ksa_engine #(.ADDR_W(2), .DATA_W(8), .KEY_BYTES(1)) u_small (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start_s),
    .secret_key (key_s),
    .busy       (busy_s),
    .done       (done_s),
    .mem_addr   (addr_s),
    .mem_wdata  (wdata_s),
    .mem_wren   (wren_s),
    .mem_rdata  (rdata_s)
`ifdef KSA_CYCLE_CNT_EN
    ,
    .cycle_cnt  (cnt_s)
`endif
  );

  always @(posedge clk) begin
    if (wren_s) begin
      mem_s[addr_s] <= wdata_s;
      wlog_s.push_back(addr_s);
    end
    rdata_s <= mem_s[addr_s];
  end

  // ---------------- default instance ----------------
  logic        start_d;
  logic [23:0] key_d;
  logic        busy_d, done_d, wren_d;
  logic [7:0]  addr_d, wdata_d, rdata_d;
  logic [7:0]  mem_d [256];
`ifdef KSA_CYCLE_CNT_EN
  logic [31:0] cnt_d;
`endif

  ksa_engine u_dflt (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start_d),
    .secret_key (key_d),
    .busy       (busy_d),
    .done       (done_d),
    .mem_addr   (addr_d),
    .mem_wdata  (wdata_d),
    .mem_wren   (wren_d),
    .mem_rdata  (rdata_d)
`ifdef KSA_CYCLE_CNT_EN
    ,
    .cycle_cnt  (cnt_d)
`endif
  );

  always @(posedge clk) begin
    if (wren_d) mem_d[addr_d] <= wdata_d;
    rdata_d <= mem_d[addr_d];
  end

  // ---------------- scoreboard ----------------
  int         n_cmp  = 0;
  int         n_fail = 0;
  logic [7:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_small(input logic [7:0] key);
    start_s = 1'b1;
    key_s   = key;
    @(posedge clk);
    #1;
    start_s = 1'b0;
  endtask

  task automatic start_dflt(input logic [23:0] key);
    start_d = 1'b1;
    key_d   = key;
    @(posedge clk);
    #1;
    start_d = 1'b0;
  endtask

  // Returns the number of edges after the start edge until done is seen, or -1 on timeout.
  task automatic wait_done_s(input int budget, output int n);
    n = 0;
    forever begin
      @(posedge clk);
      n++;
      #1;
      if (done_s) break;
      if (n >= budget) begin n = -1; break; end
    end
  endtask

  task automatic wait_done_d(input int budget, output int n);
    n = 0;
    forever begin
      @(posedge clk);
      n++;
      #1;
      if (done_d) break;
      if (n >= budget) begin n = -1; break; end
    end
  endtask

  task automatic check_small_ram(input string tag);
    for (int k = 0; k < 4; k++) check(tag, mem_s[k], exp_q.pop_front());
  endtask

  // Software reference for the RC4 key schedule at the default size.
  task automatic load_rc4_model(input logic [23:0] key);
    logic [7:0] s [256];
    logic [7:0] kb [3];
    logic [7:0] t;
    int         jj;
    kb[0] = key[23:16];
    kb[1] = key[15:8];
    kb[2] = key[7:0];
    for (int k = 0; k < 256; k++) s[k] = 8'(k);
    jj = 0;
    for (int k = 0; k < 256; k++) begin
      jj    = (jj + int'(s[k]) + int'(kb[k % 3])) % 256;
      t     = s[k];
      s[k]  = s[jj];
      s[jj] = t;
    end
    exp_q.delete();
    for (int k = 0; k < 256; k++) exp_q.push_back(s[k]);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lat;
    int done_cnt;
    int first_done;

    reset_n = 1'b0;
    start_s = 1'b0;
    key_s   = '0;
    start_d = 1'b0;
    key_d   = '0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    check("rst_busy_s",  busy_s,  0);
    check("rst_done_s",  done_s,  0);
    check("rst_wren_s",  wren_s,  0);
    check("rst_addr_s",  addr_s,  0);
    check("rst_wdata_s", wdata_s, 0);
    check("rst_busy_d",  busy_d,  0);
    check("rst_wren_d",  wren_d,  0);
`ifdef KSA_CYCLE_CNT_EN
    check("rst_cnt_d",   cnt_d,   0);
`endif
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Small instance, key 00: expected RAM {0,2,3,1}, done 28 edges after the start edge
    start_small(8'h00);
    check("k00_busy_after_start", busy_s, 1);
    wait_done_s(100, lat);
    check("k00_latency", lat, 28);
    check("k00_busy_on_done", busy_s, 0);
    @(posedge clk);
    #1;
    check("k00_done_one_cycle", done_s, 0);
    exp_q.delete();
    exp_q.push_back(8'd0); exp_q.push_back(8'd2); exp_q.push_back(8'd3); exp_q.push_back(8'd1);
    check_small_ram("k00_ram");

    // Key 02 with disturbances: the key changes after the start edge, start is pulsed
    // mid-scramble and again in the DONE cycle. Expected RAM is {2,0,3,1} with one done.
    start_small(8'h02);
    key_s      = 8'h00;
    done_cnt   = 0;
    first_done = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (n == 10) start_s = 1'b1;
      if (n == 11) start_s = 1'b0;
      if (done_s) begin
        done_cnt++;
        if (first_done == 0) first_done = n;
        start_s = 1'b1;
      end else if (first_done != 0 && n == first_done + 1) begin
        start_s = 1'b0;
        check("k02_busy_after_done_start", busy_s, 0);
      end
    end
    check("k02_latency", first_done, 28);
    check("k02_done_count", done_cnt, 1);
    check("k02_idle_end", busy_s, 0);
    exp_q.delete();
    exp_q.push_back(8'd2); exp_q.push_back(8'd0); exp_q.push_back(8'd3); exp_q.push_back(8'd1);
    check_small_ram("k02_ram");

    // Reset during WR_I of the first iteration (8 edges after the start edge)
    start_small(8'h01);
    repeat (8) @(posedge clk);
    #1;
    check("wr_i_wren", wren_s, 1);
    check("wr_i_addr", addr_s, 0);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_busy", busy_s, 0);
    check("abort_wren", wren_s, 0);
    check("abort_done", done_s, 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Fresh run with key 01: RAM {0,2,3,1}. The write log holds the 4 INIT addresses
    // followed by an (i, j) pair per iteration, with the j trace 1,2,3,0.
    wlog_s.delete();
    start_small(8'h01);
    wait_done_s(100, lat);
    check("k01_latency", lat, 28);
    exp_q.delete();
    exp_q.push_back(8'd0); exp_q.push_back(8'd2); exp_q.push_back(8'd3); exp_q.push_back(8'd1);
    check_small_ram("k01_ram");
    check("k01_write_count", wlog_s.size(), 12);
    exp_q.delete();
    exp_q.push_back(8'd0); exp_q.push_back(8'd1); exp_q.push_back(8'd2); exp_q.push_back(8'd3);
    exp_q.push_back(8'd0); exp_q.push_back(8'd1); exp_q.push_back(8'd1); exp_q.push_back(8'd2);
    exp_q.push_back(8'd2); exp_q.push_back(8'd3); exp_q.push_back(8'd3); exp_q.push_back(8'd0);
    for (int k = 0; k < 12; k++) begin
      if (k < wlog_s.size()) check("k01_write_addr", wlog_s[k], exp_q.pop_front());
    end

    // Default instance, key 000249: compared against the software RC4 schedule
    start_dflt(24'h000249);
    check("dflt_busy_after_start", busy_d, 1);
    wait_done_d(2000, lat);
    check("dflt_latency", lat, 1792);
`ifdef KSA_CYCLE_CNT_EN
    check("dflt_cnt_at_done", cnt_d, 1792);
`endif
    load_rc4_model(24'h000249);
    for (int k = 0; k < 256; k++) check("dflt_ram", mem_d[k], exp_q.pop_front());
`ifdef KSA_CYCLE_CNT_EN
    repeat (5) @(posedge clk);
    #1;
    check("dflt_cnt_held", cnt_d, 1792);
    start_dflt(24'h000249);
    check("dflt_cnt_cleared", cnt_d, 0);
    wait_done_d(2000, lat);
    check("dflt_cnt_second_run", cnt_d, 1792);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
